// File: rtl/ir_nec_pkg.sv
// Shared constants for the NEC IR receiver: state encoding, pulse-width windows (us), frame size.
package ir_nec_pkg;

  localparam int WIDTH_BITS = 14;
  typedef logic [WIDTH_BITS-1:0] width_t;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_LEAD_MARK  = 3'd1;
  localparam logic [2:0] ST_LEAD_SPACE = 3'd2;
  localparam logic [2:0] ST_BIT_MARK   = 3'd3;
  localparam logic [2:0] ST_BIT_SPACE  = 3'd4;
  localparam logic [2:0] ST_CHECK      = 3'd5;

  localparam width_t LEAD_MARK_MIN    = 14'd8000;
  localparam width_t LEAD_MARK_MAX    = 14'd10000;
  localparam width_t LEAD_SPACE_MIN   = 14'd4000;
  localparam width_t LEAD_SPACE_MAX   = 14'd5000;
  localparam width_t REPEAT_SPACE_MIN = 14'd2000;
  localparam width_t REPEAT_SPACE_MAX = 14'd2500;
  localparam width_t BIT_MARK_MIN     = 14'd400;
  localparam width_t BIT_MARK_MAX     = 14'd700;
  localparam width_t ZERO_SPACE_MIN   = 14'd400;
  localparam width_t ZERO_SPACE_MAX   = 14'd700;
  localparam width_t ONE_SPACE_MIN    = 14'd1400;
  localparam width_t ONE_SPACE_MAX    = 14'd1900;

  localparam int NEC_BITS = 32;

  function automatic logic in_window(input width_t w, input width_t lo, input width_t hi);
    return (w >= lo) && (w <= hi);
  endfunction

endpackage

// File: rtl/ir_input_sync.sv
// Two-flop synchronizer plus one delay flop; emits single-cycle fall/rise strobes for an async input.
module ir_input_sync #(
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic fall,
  output logic rise
);

  logic s1, s2, s3;

  // Flops reset to the idle line level so leaving reset never fakes an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= IDLE_LEVEL;
      s2 <= IDLE_LEVEL;
      s3 <= IDLE_LEVEL;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign fall = s3 & ~s2;
  assign rise = ~s3 & s2;

endmodule

// File: rtl/ir_nec_decoder.sv
// NEC IR frame decoder: measures mark/space widths in microseconds and latches address/command.
//   state      | meaning
//   IDLE       | waiting for a leader mark to start
//   LEAD_MARK  | timing the 9 ms leader mark
//   LEAD_SPACE | timing the 4.5 ms (frame) or 2.25 ms (repeat) space
//   BIT_MARK   | timing a 560 us bit mark
//   BIT_SPACE  | timing a bit space, shifting in 0 or 1
//   CHECK      | validating the inverted byte pairs
module ir_nec_decoder
  import ir_nec_pkg::*;
#(
  parameter int CLKS_PER_US = 50,
  parameter int TIMEOUT_US  = 12000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ir_in,
  input  logic       ack,
  output logic [7:0] addr_out,
  output logic [7:0] cmd_out,
  output logic       new_data,
  output logic       overrun,
  output logic       frame_pulse,
  output logic       repeat_pulse,
  output logic       err_pulse
);

  localparam int PRE_W = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLKS_PER_US - 1);
  localparam width_t TIMEOUT_W = WIDTH_BITS'(TIMEOUT_US);
  localparam logic [5:0] LAST_BIT = 6'(NEC_BITS - 1);

  logic                fall, rise, us_tick, bit_one, bit_zero, frame_ok;
  logic [PRE_W-1:0]    pre_cnt;
  width_t              width_cnt;
  logic [2:0]          state;
  logic [5:0]          bit_cnt;
  logic [NEC_BITS-1:0] shreg;
  logic                have_last;

  ir_input_sync #(.IDLE_LEVEL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .din   (ir_in),
    .fall  (fall),
    .rise  (rise)
  );

  assign us_tick = (pre_cnt == PRE_LAST);

  always_ff @(posedge clk) begin
    if (reset || us_tick) pre_cnt <= '0;
    else                  pre_cnt <= pre_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset || fall || rise)                  width_cnt <= '0;
    else if (us_tick && width_cnt != TIMEOUT_W) width_cnt <= width_cnt + 1'b1;
  end

  assign bit_zero = in_window(width_cnt, ZERO_SPACE_MIN, ZERO_SPACE_MAX);
  assign bit_one  = in_window(width_cnt, ONE_SPACE_MIN, ONE_SPACE_MAX);
  assign frame_ok = (shreg[15:8] == ~shreg[7:0]) && (shreg[31:24] == ~shreg[23:16]);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      bit_cnt      <= '0;
      shreg        <= '0;
      have_last    <= 1'b0;
      addr_out     <= '0;
      cmd_out      <= '0;
      new_data     <= 1'b0;
      overrun      <= 1'b0;
      frame_pulse  <= 1'b0;
      repeat_pulse <= 1'b0;
      err_pulse    <= 1'b0;
    end else begin
      frame_pulse  <= 1'b0;
      repeat_pulse <= 1'b0;
      err_pulse    <= 1'b0;
      if (ack) begin
        new_data <= 1'b0;
        overrun  <= 1'b0;
      end
      if (state != ST_IDLE && width_cnt == TIMEOUT_W) begin
        err_pulse <= 1'b1;
        state     <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE:
            if (fall) state <= ST_LEAD_MARK;
          ST_LEAD_MARK:
            if (rise) state <= in_window(width_cnt, LEAD_MARK_MIN, LEAD_MARK_MAX) ? ST_LEAD_SPACE : ST_IDLE;
          ST_LEAD_SPACE:
            if (fall) begin
              if (in_window(width_cnt, LEAD_SPACE_MIN, LEAD_SPACE_MAX)) begin
                state   <= ST_BIT_MARK;
                bit_cnt <= '0;
              end else if (in_window(width_cnt, REPEAT_SPACE_MIN, REPEAT_SPACE_MAX)) begin
                repeat_pulse <= have_last;
                state        <= ST_IDLE;
              end else begin
                err_pulse <= 1'b1;
                state     <= ST_IDLE;
              end
            end
          ST_BIT_MARK:
            if (rise) begin
              if (in_window(width_cnt, BIT_MARK_MIN, BIT_MARK_MAX)) begin
                state <= ST_BIT_SPACE;
              end else begin
                err_pulse <= 1'b1;
                state     <= ST_IDLE;
              end
            end
          ST_BIT_SPACE:
            if (fall) begin
              if (bit_zero || bit_one) begin
                shreg   <= {bit_one, shreg[NEC_BITS-1:1]};
                bit_cnt <= bit_cnt + 1'b1;
                state   <= (bit_cnt == LAST_BIT) ? ST_CHECK : ST_BIT_MARK;
              end else begin
                err_pulse <= 1'b1;
                state     <= ST_IDLE;
              end
            end
          ST_CHECK: begin
            if (frame_ok) begin
              addr_out    <= shreg[7:0];
              cmd_out     <= shreg[23:16];
              frame_pulse <= 1'b1;
              have_last   <= 1'b1;
              new_data    <= 1'b1;
              // A simultaneous ack still consumes the overrun condition.
              overrun     <= ~ack & (overrun | new_data);
            end else begin
              err_pulse <= 1'b1;
            end
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ir_nec_decoder.sv
// Directed + randomized bench for ir_nec_decoder at 1 clk per us, with a frame-level reference model.
module tb_ir_nec_decoder;

  logic       clk = 1'b0;
  logic       reset, ir_in, ack;
  logic [7:0] addr_out, cmd_out;
  logic       new_data, overrun, frame_pulse, repeat_pulse, err_pulse;

  always #5 clk = ~clk;

  ir_nec_decoder #(.CLKS_PER_US(1), .TIMEOUT_US(12000)) dut (
    .clk          (clk),
    .reset        (reset),
    .ir_in        (ir_in),
    .ack          (ack),
    .addr_out     (addr_out),
    .cmd_out      (cmd_out),
    .new_data     (new_data),
    .overrun      (overrun),
    .frame_pulse  (frame_pulse),
    .repeat_pulse (repeat_pulse),
    .err_pulse    (err_pulse)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int n_frame = 0, n_rep = 0, n_err = 0, err_at = 0;

  logic [7:0] m_addr, m_cmd;
  logic       m_new, m_over, m_have;

  always @(negedge clk) begin
    cyc++;
    if (frame_pulse)  n_frame++;
    if (repeat_pulse) n_rep++;
    if (err_pulse) begin
      n_err++;
      err_at = cyc;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic seg(input logic lvl, input int us);
    ir_in = lvl;
    tick(us);
  endtask

  task automatic clr();
    n_frame = 0;
    n_rep   = 0;
    n_err   = 0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".addr"}, 32'(addr_out), 32'(m_addr));
    check({tag, ".cmd"},  32'(cmd_out),  32'(m_cmd));
    check({tag, ".new"},  32'(new_data), 32'(m_new));
    check({tag, ".ovr"},  32'(overrun),  32'(m_over));
  endtask

  function automatic int rnd(input int lo, input int hi);
    return int'($urandom_range(hi, lo));
  endfunction

  // Frame-level reference: what a good/bad frame does to the held registers.
  function automatic logic model_frame(input logic [31:0] d, input logic ack_now);
    logic good;
    good = (d[15:8] == ~d[7:0]) && (d[31:24] == ~d[23:16]);
    if (good) begin
      m_over = ack_now ? 1'b0 : (m_over | m_new);
      m_new  = 1'b1;
      m_addr = d[7:0];
      m_cmd  = d[23:16];
      m_have = 1'b1;
    end
    return good;
  endfunction

  function automatic logic [31:0] nec_word(input logic [7:0] a, input logic [7:0] c);
    return {~c, c, ~a, a};
  endfunction

  task automatic send_head(input logic [31:0] d, input int nbits, input bit jit);
    seg(1'b0, jit ? rnd(8200, 9800) : 9000);
    seg(1'b1, jit ? rnd(4100, 4900) : 4500);
    for (int i = 0; i < nbits; i++) begin
      seg(1'b0, jit ? rnd(450, 680) : 560);
      if (d[i]) seg(1'b1, jit ? rnd(1450, 1880) : 1690);
      else      seg(1'b1, jit ? rnd(450, 680) : 560);
    end
  endtask

  // The stop-mark fall reaches CHECK on the 4th edge; ack is placed on that edge when requested.
  task automatic send_frame(input logic [31:0] d, input bit jit, input logic ack_now, output logic fp);
    send_head(d, 32, jit);
    ir_in = 1'b0;
    tick(3);
    ack = ack_now;
    tick(1);
    ack = 1'b0;
    fp = frame_pulse;
    tick(556);
    ir_in = 1'b1;
    tick(1000);
  endtask

  task automatic send_repeat();
    seg(1'b0, 9000);
    seg(1'b1, 2250);
    seg(1'b0, 560);
    seg(1'b1, 1000);
  endtask

  initial begin
    logic [31:0] d;
    logic        fp, good;
    int          t0, delta;

    m_addr = '0; m_cmd = '0; m_new = 1'b0; m_over = 1'b0; m_have = 1'b0;
    reset = 1'b1; ir_in = 1'b1; ack = 1'b0;
    tick(5);
    check_regs("reset");
    check("reset.pulses", 32'({frame_pulse, repeat_pulse, err_pulse}), 0);
    reset = 1'b0;
    tick(20);

    clr();
    send_repeat();
    check("rep_no_last.rep", n_rep, 0);
    check("rep_no_last.err", n_err, 0);

    clr();
    seg(1'b0, 3000);
    seg(1'b1, 5000);
    check("short_lead.pulses", n_frame + n_rep + n_err, 0);

    clr();
    t0 = cyc;
    seg(1'b0, 15000);
    seg(1'b1, 500);
    delta = err_at - t0;
    check("stuck_low.err", n_err, 1);
    check("stuck_low.time", 32'(delta >= 11999 && delta <= 12008), 1);
    check("stuck_low.other", n_frame + n_rep, 0);

    clr();
    send_head($urandom, 3, 1'b1);
    seg(1'b0, 560);
    seg(1'b1, 1000);
    seg(1'b0, 600);
    seg(1'b1, 1000);
    check("bad_space.err", n_err, 1);
    check("bad_space.frame", n_frame, 0);

    clr();
    d = {8'hBB, 8'h45, 8'hFF, 8'h00};
    send_frame(d, 1'b0, 1'b0, fp);
    good = model_frame(d, 1'b0);
    check("bad_inv.err", n_err, 32'(!good));
    check("bad_inv.frame", n_frame, 32'(good));
    check_regs("bad_inv");

    clr();
    d = nec_word(8'h00, 8'h45);
    send_frame(d, 1'b0, 1'b0, fp);
    good = model_frame(d, 1'b0);
    check("f45.frame", n_frame, 32'(good));
    check("f45.err", n_err, 0);
    check_regs("f45");

    clr();
    send_repeat();
    check("rep.rep", n_rep, 32'(m_have));
    check("rep.err", n_err, 0);
    check_regs("rep");

    clr();
    d = nec_word(8'($urandom), 8'($urandom));
    send_frame(d, 1'b1, 1'b0, fp);
    good = model_frame(d, 1'b0);
    check("ovr.frame", n_frame, 32'(good));
    check_regs("ovr");

    clr();
    d = nec_word(8'($urandom), 8'($urandom));
    send_frame(d, 1'b1, 1'b1, fp);
    good = model_frame(d, 1'b1);
    check("ack_chk.fp_align", 32'(fp), 1);
    check("ack_chk.frame", n_frame, 32'(good));
    check_regs("ack_chk");

    clr();
    send_head(nec_word(8'($urandom), 8'($urandom)), 10, 1'b1);
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    m_addr = '0; m_cmd = '0; m_new = 1'b0; m_over = 1'b0; m_have = 1'b0;
    tick(5);
    check("mid_reset.err", n_err, 0);
    check_regs("mid_reset");

    clr();
    d = nec_word(8'h10, 8'h07);
    send_frame(d, 1'b1, 1'b0, fp);
    good = model_frame(d, 1'b0);
    check("after_reset.frame", n_frame, 32'(good));
    check("after_reset.err", n_err, 0);
    check_regs("after_reset");

    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    m_new = 1'b0;
    m_over = 1'b0;
    tick(1);
    check_regs("ack");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
